// File: rtl/dds_ftw_pkg.sv
// Shared constants for the DDS FTW scheduler: the channel-select table, the DDS
// register addresses and command codes, and the scheduler state encoding.
package dds_ftw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_UPD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Entry i is the channel-select byte for channel i.
  localparam logic [3:0][7:0] CH_SEL = {8'h28, 8'h14, 8'h82, 8'h41};

  localparam logic [15:0] ADDR_CH  = 16'h0008;
  localparam logic [15:0] ADDR_CFR = 16'h0113;
  localparam logic [15:0] ADDR_FTW = 16'h0114;

  localparam logic [7:0] CODE_WR  = 8'h02;
  localparam logic [7:0] CODE_UPD = 8'h03;

endpackage

// File: rtl/dds_ftw_sched_rr_arb.sv
// Round-robin arbiter: grants the first requesting channel at or after ptr,
// wrapping around. The grant is one-hot, or all zero when nothing requests.
module rr_arb #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (int'(ptr) + k) % N)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dds_ftw_sched.sv
// DDS frequency-tuning-word scheduler: captures per-channel FTWs, writes them over
// SPI one channel at a time, then issues one delayed, coalesced IO-update.
//
// state   | meaning
// IDLE    | waiting; dispatches a pending write, else a due update
// WR      | streaming the channel-select, mode and FTW bytes for one channel
// UPD     | streaming the channel mask and IO-update command
// DONE    | one-cycle gap before returning to IDLE
module dds_ftw_sched
  import dds_ftw_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int FTW_BYTES = 6,
  parameter int UPD_DLY   = 1250,
  parameter int TMR_W     = 12
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*8*FTW_BYTES-1:0] ftw,
  input  logic [NUM_CH-1:0]             ftw_vld,
  output logic [23:0]                   cmd_data,
  output logic                          cmd_vld,
  input  logic                          cmd_rdy,
  output logic                          busy,
  output logic [NUM_CH-1:0]             upd_done
);

  localparam int FTW_W = 8 * FTW_BYTES;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IDX_W = $clog2(FTW_BYTES + 2);
  localparam logic [IDX_W-1:0] WR_LAST  = IDX_W'(FTW_BYTES + 1);
  localparam logic [IDX_W-1:0] UPD_LAST = IDX_W'(1);
  localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(UPD_DLY);

  typedef logic [FTW_BYTES-1:0][7:0] ftw_t;

  state_t            state;
  ftw_t              hold [NUM_CH];
  ftw_t              work;
  ftw_t              gnt_hold;
  logic [NUM_CH-1:0] wr_pend, upd_pend, cur, mask, gnt, wr_clr;
  logic [CH_W-1:0]   ptr, nxt_ptr;
  logic [IDX_W-1:0]  idx, nxt_idx;
  logic [TMR_W-1:0]  timer;
  logic [7:0]        gnt_sel, pend_sel;
  logic [23:0]       wr_word;
  logic              accept;

  rr_arb #(.N(NUM_CH), .PW(CH_W)) u_arb (
    .req (wr_pend),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign accept = cmd_vld & cmd_rdy;
  // The grant only consumes a pending bit on the cycle IDLE actually dispatches it.
  assign wr_clr = (state == ST_IDLE) ? gnt : '0;
  assign nxt_idx = idx + IDX_W'(1);

  always_comb begin
    gnt_sel  = '0;
    gnt_hold = '0;
    nxt_ptr  = '0;
    pend_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        gnt_sel  = CH_SEL[i];
        gnt_hold = hold[i];
        nxt_ptr  = (i == NUM_CH - 1) ? '0 : CH_W'(i + 1);
      end
      if (upd_pend[i]) pend_sel = pend_sel | CH_SEL[i];
    end
    wr_word = '0;
    if (nxt_idx == IDX_W'(1)) wr_word = {ADDR_CFR, CODE_WR};
    for (int k = 0; k < FTW_BYTES; k++) begin
      if (int'(nxt_idx) == k + 2) wr_word = {ADDR_FTW + 16'(k), work[k]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
      work     <= '0;
      wr_pend  <= '0;
      upd_pend <= '0;
      cur      <= '0;
      mask     <= '0;
      ptr      <= '0;
      idx      <= '0;
      timer    <= '0;
      cmd_data <= '0;
      cmd_vld  <= 1'b0;
      busy     <= 1'b0;
      upd_done <= '0;
    end else begin
      upd_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ftw_vld[i]) hold[i] <= ftw[i*FTW_W +: FTW_W];
      end
      // A strobe landing on the dispatch cycle wins, so that value is written later.
      wr_pend <= (wr_pend & ~wr_clr) | ftw_vld;

      // Timer is held at zero while nothing awaits update, so it restarts only on 0->nonzero.
      if (upd_pend == '0)        timer <= '0;
      else if (timer != TMR_END) timer <= timer + TMR_W'(1);

      case (state)
        ST_IDLE: begin
          if (|wr_pend) begin
            state    <= ST_WR;
            busy     <= 1'b1;
            cur      <= gnt;
            work     <= gnt_hold;
            ptr      <= nxt_ptr;
            idx      <= '0;
            cmd_vld  <= 1'b1;
            cmd_data <= {ADDR_CH, gnt_sel};
          end else if ((|upd_pend) && timer == TMR_END) begin
            state    <= ST_UPD;
            busy     <= 1'b1;
            mask     <= upd_pend;
            upd_pend <= '0;
            idx      <= '0;
            cmd_vld  <= 1'b1;
            cmd_data <= {ADDR_CH, pend_sel};
          end
        end
        ST_WR: begin
          if (accept) begin
            if (idx == WR_LAST) begin
              cmd_vld  <= 1'b0;
              upd_pend <= upd_pend | cur;
              state    <= ST_DONE;
            end else begin
              idx      <= nxt_idx;
              cmd_data <= wr_word;
            end
          end
        end
        ST_UPD: begin
          if (accept) begin
            if (idx == UPD_LAST) begin
              cmd_vld  <= 1'b0;
              upd_done <= mask;
              timer    <= '0;
              state    <= ST_DONE;
            end else begin
              idx      <= nxt_idx;
              cmd_data <= {ADDR_CFR, CODE_UPD};
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          cmd_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_ftw_sched.sv
// Directed bench for dds_ftw_sched: table of single-channel writes plus hand-written
// sequences for coalescing, round-robin, back-pressure, rewrite and mid-write reset.
module tb_dds_ftw_sched;

  localparam int UPD_DLY = 1250;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [95:0] ftw;
  logic [1:0]  ftw_vld;
  logic [23:0] cmd_data;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        busy;
  logic [1:0]  upd_done;

  dds_ftw_sched #(.NUM_CH(2), .FTW_BYTES(6), .UPD_DLY(UPD_DLY), .TMR_W(12)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .ftw      (ftw),
    .ftw_vld  (ftw_vld),
    .cmd_data (cmd_data),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .busy     (busy),
    .upd_done (upd_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } ev_t;

  typedef struct {
    int          ch;
    logic [47:0] f;
    logic [7:0]  sel;
    logic [1:0]  done;
  } vec_t;

  ev_t         hist[$];
  ev_t         dones[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  always @(posedge sys_clk) cyc++;

  // Words are logged at the negedge before the edge that accepts them.
  always @(negedge sys_clk) begin
    if (rst_n && prev_stall) begin
      checks++;
      if (!cmd_vld || cmd_data !== prev_data) begin
        errors++;
        $display("FAIL stall_hold: vld=%b data=%h required vld=1 data=%h", cmd_vld, cmd_data, prev_data);
      end
    end
    prev_stall = rst_n && cmd_vld && !cmd_rdy;
    prev_data  = cmd_data;
    if (rst_n && cmd_vld && cmd_rdy) hist.push_back('{data: cmd_data, cyc: cyc});
    if (upd_done != 2'b00) dones.push_back('{data: 24'(upd_done), cyc: cyc});
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] hw(input int k);
    if (k < hist.size()) return hist[k].data;
    return 'x;
  endfunction

  function automatic int hc(input int k);
    if (k < hist.size()) return hist[k].cyc;
    return -100000;
  endfunction

  function automatic logic [23:0] dv(input int k);
    if (k < dones.size()) return dones[k].data;
    return 'x;
  endfunction

  task automatic wait_for(input string name, input int nw, input int nd, input int budget);
    int n;
    n = 0;
    while ((hist.size() < nw || dones.size() < nd) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (hist.size() < nw || dones.size() < nd) begin
      errors++;
      $display("FAIL %s_timeout: got %0d words %0d updates required %0d words %0d updates",
               name, hist.size(), dones.size(), nw, nd);
    end
  endtask

  task automatic strobe(input logic [1:0] v, input logic [47:0] f0, input logic [47:0] f1);
    ftw     = {f1, f0};
    ftw_vld = v;
    tick();
    ftw_vld = 2'b00;
  endtask

  task automatic clear_logs();
    hist.delete();
    dones.delete();
  endtask

  vec_t        vecs [3];
  logic [23:0] exp_w [3][8];

  initial begin
    int s;
    vecs[0]  = '{ch: 0, f: 48'h0123456789AB, sel: 8'h41, done: 2'b01};
    exp_w[0] = '{24'h000841, 24'h011302, 24'h0114AB, 24'h011589,
                 24'h011667, 24'h011745, 24'h011823, 24'h011901};
    vecs[1]  = '{ch: 1, f: 48'hFEDCBA987654, sel: 8'h82, done: 2'b10};
    exp_w[1] = '{24'h000882, 24'h011302, 24'h011454, 24'h011576,
                 24'h011698, 24'h0117BA, 24'h0118DC, 24'h0119FE};
    vecs[2]  = '{ch: 0, f: 48'hFF0000000001, sel: 8'h41, done: 2'b01};
    exp_w[2] = '{24'h000841, 24'h011302, 24'h011401, 24'h011500,
                 24'h011600, 24'h011700, 24'h011800, 24'h0119FF};

    rst_n   = 1'b0;
    ftw     = '0;
    ftw_vld = 2'b00;
    cmd_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_vld", 24'(cmd_vld), 24'h0);
    chk("rst_cmd_data", cmd_data, 24'h0);
    chk("rst_busy", 24'(busy), 24'h0);
    chk("rst_upd_done", 24'(upd_done), 24'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single-channel writes with full update, cmd_rdy held high.
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      s = cyc;
      if (vecs[i].ch == 0) strobe(2'b01, vecs[i].f, 48'h0);
      else                 strobe(2'b10, 48'h0, vecs[i].f);
      wait_for($sformatf("v%0d", i), 10, 1, UPD_DLY + 100);
      repeat (3) tick();
      chk_int($sformatf("v%0d_latency", i), hc(0) - s, 2);
      for (int k = 0; k < 8; k++) chk($sformatf("v%0d_w%0d", i, k), hw(k), exp_w[i][k]);
      chk_int($sformatf("v%0d_b2b", i), hc(7) - hc(0), 7);
      chk($sformatf("v%0d_upd_sel", i), hw(8), {16'h0008, vecs[i].sel});
      chk($sformatf("v%0d_upd_cmd", i), hw(9), 24'h011303);
      chk_int($sformatf("v%0d_upd_delay", i), hc(8) - hc(7), UPD_DLY + 2);
      chk_int($sformatf("v%0d_words", i), hist.size(), 10);
      chk_int($sformatf("v%0d_ndone", i), dones.size(), 1);
      chk($sformatf("v%0d_done", i), dv(0), 24'(vecs[i].done));
      if (dones.size() > 0) chk_int($sformatf("v%0d_done_cyc", i), dones[0].cyc, hc(9) + 1);
      repeat (3) tick();
    end

    // Two channels 100 cycles apart coalesce into one update; timer not restarted.
    clear_logs();
    strobe(2'b01, 48'h0123456789AB, 48'h0);
    repeat (99) tick();
    strobe(2'b10, 48'h0123456789AB, 48'hFEDCBA987654);
    wait_for("coal", 18, 1, UPD_DLY + 200);
    repeat (3) tick();
    chk("coal_ch0_hdr", hw(0), 24'h000841);
    chk("coal_ch0_b0", hw(2), 24'h0114AB);
    chk("coal_ch1_hdr", hw(8), 24'h000882);
    chk("coal_ch1_b5", hw(15), 24'h0119FE);
    chk("coal_upd_sel", hw(16), 24'h0008C3);
    chk("coal_upd_cmd", hw(17), 24'h011303);
    chk_int("coal_upd_delay", hc(16) - hc(7), UPD_DLY + 2);
    chk_int("coal_words", hist.size(), 18);
    chk_int("coal_ndone", dones.size(), 1);
    chk("coal_done", dv(0), 24'h3);
    repeat (3) tick();

    // Simultaneous pair, then a second pair during ch0's write: ch1 must go before ch0.
    clear_logs();
    strobe(2'b11, 48'h111111111111, 48'h222222222222);
    wait_for("rr_mid", 3, 0, 20);
    strobe(2'b11, 48'h333333333333, 48'h444444444444);
    wait_for("rr", 26, 1, UPD_DLY + 200);
    repeat (3) tick();
    chk("rr_first_hdr", hw(0), 24'h000841);
    chk("rr_first_b0", hw(2), 24'h011411);
    chk("rr_second_hdr", hw(8), 24'h000882);
    chk("rr_second_b0", hw(10), 24'h011444);
    chk("rr_third_hdr", hw(16), 24'h000841);
    chk("rr_third_b0", hw(18), 24'h011433);
    chk("rr_upd_sel", hw(24), 24'h0008C3);
    chk_int("rr_words", hist.size(), 26);
    chk("rr_done", dv(0), 24'h3);
    repeat (3) tick();

    // Random back-pressure: same words, none lost or duplicated.
    clear_logs();
    cmd_rdy = 1'b0;
    strobe(2'b10, 48'h0, 48'hFEDCBA987654);
    for (int n = 0; n < 5000 && !(hist.size() >= 10 && dones.size() >= 1); n++) begin
      cmd_rdy = 1'($urandom_range(0, 1));
      tick();
    end
    cmd_rdy = 1'b1;
    repeat (5) tick();
    for (int k = 0; k < 8; k++) chk($sformatf("bp_w%0d", k), hw(k), exp_w[1][k]);
    chk("bp_upd_sel", hw(8), 24'h000882);
    chk("bp_upd_cmd", hw(9), 24'h011303);
    chk_int("bp_words", hist.size(), 10);
    chk("bp_done", dv(0), 24'h2);

    // Rewrite of ch0 mid-sequence: two write passes, one update.
    clear_logs();
    strobe(2'b01, 48'hA1A2A3A4A5A6, 48'h0);
    wait_for("rw_mid", 4, 0, 20);
    strobe(2'b01, 48'hB1B2B3B4B5B6, 48'h0);
    wait_for("rw", 18, 1, UPD_DLY + 200);
    repeat (20) tick();
    chk("rw_first_b0", hw(2), 24'h0114A6);
    chk("rw_first_b5", hw(7), 24'h0119A1);
    chk("rw_second_hdr", hw(8), 24'h000841);
    chk("rw_second_b0", hw(10), 24'h0114B6);
    chk("rw_second_b5", hw(15), 24'h0119B1);
    chk("rw_upd_sel", hw(16), 24'h000841);
    chk_int("rw_upd_delay", hc(16) - hc(7), UPD_DLY + 2);
    chk_int("rw_words", hist.size(), 18);
    chk_int("rw_ndone", dones.size(), 1);
    chk("rw_done", dv(0), 24'h1);

    // Reset during word 4 of a write: outputs clear and no update follows.
    clear_logs();
    strobe(2'b01, 48'h0123456789AB, 48'h0);
    wait_for("rst_mid", 4, 0, 20);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cmd_vld", 24'(cmd_vld), 24'h0);
    chk("mid_rst_cmd_data", cmd_data, 24'h0);
    chk("mid_rst_busy", 24'(busy), 24'h0);
    chk("mid_rst_upd_done", 24'(upd_done), 24'h0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (UPD_DLY + 100) tick();
    chk_int("post_rst_words", hist.size(), 0);
    chk_int("post_rst_ndone", dones.size(), 0);
    chk("post_rst_busy", 24'(busy), 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/dds_ftw_sched.md
DDS_FTW_SCHED -- requirements
Module: dds_ftw_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of DDS channels, legal range 1..4.
REQ-002 SHALL have parameter FTW_BYTES, default 6: FTW width in bytes, legal range 1..8.
REQ-003 SHALL have parameter UPD_DLY, default 1250: sys_clk cycles from first pending update to IO-update issue.
REQ-004 SHALL have parameter TMR_W, default 12: width of the update timer; UPD_DLY < 2^TMR_W.
REQ-005 SHALL have ports: sys_clk in 1 -- clock; rst_n in 1 -- reset, synchronous, active-low.
REQ-006 SHALL have port ftw in NUM_CH*8*FTW_BYTES: per-channel FTW; channel i occupies slice i.
REQ-007 SHALL have port ftw_vld in NUM_CH: one-cycle capture strobe per channel.
REQ-008 SHALL have ports: cmd_data out 24 -- SPI command {addr16, data8}; cmd_vld out 1 -- command valid.
REQ-009 SHALL have port cmd_rdy in 1: SPI master accepts cmd_data when cmd_vld && cmd_rdy.
REQ-010 SHALL have ports: busy out 1 -- engine not IDLE; upd_done out NUM_CH -- one-cycle pulse per updated channel.

Function
REQ-011 SHALL latch ftw slice i into hold[i] and set wr_pend[i] on ftw_vld[i], in any state.
REQ-012 SHALL use a 4-state FSM: IDLE, WR (channel write sequence), UPD (IO-update sequence), DONE (one cycle).
REQ-013 SHALL, in IDLE, select WR when any wr_pend is set, picking round-robin from the channel after the last one written.
REQ-014 SHALL, on entering WR for channel c, snapshot hold[c] into the work register and clear wr_pend[c].
REQ-015 SHALL, in WR, issue FTW_BYTES+2 words in order: {16'h0008, CH_SEL[c]}, {16'h0113, 8'h02}, then {16'h0114+k, work[8k+7:8k]} for k = 0..FTW_BYTES-1.
REQ-016 SHALL, on acceptance of the last WR word, set upd_pend[c] and go to DONE.
REQ-017 SHALL run the update timer while upd_pend != 0: start from 0 on the first 0->nonzero transition; do not restart on later writes; saturate at UPD_DLY.
REQ-018 SHALL, in IDLE, enter UPD when timer == UPD_DLY and no wr_pend is set; writes have priority over updates.
REQ-019 SHALL, on UPD entry, snapshot upd_pend to mask m and clear those bits.
REQ-020 SHALL, in UPD, issue {16'h0008, OR of CH_SEL[i] over m}, then {16'h0113, 8'h03}.
REQ-021 SHALL, on acceptance of the last UPD word, pulse upd_done = m for one cycle, clear the timer, and go to DONE.
REQ-022 SHALL go from DONE to IDLE unconditionally.
REQ-023 SHALL hold cmd_vld and cmd_data stable until cmd_rdy; cmd_vld never drops without acceptance; cmd_rdy is ignored while cmd_vld is low.
REQ-024 SHALL give a latency of 2 cycles from ftw_vld in IDLE to the first cmd_vld, and issue back-to-back words when cmd_rdy is held high.
REQ-025 SHALL resolve same-cycle set and clear of wr_pend[c] as set: the new value is written again later, and the snapshot holds the pre-strobe value.
REQ-026 SHALL keep upd_pend[c] set when channel c is rewritten before its update issues, with no duplicate update.
REQ-027 SHALL treat ftw_vld bits at index >= NUM_CH as absent; unused CH_SEL entries are never referenced.

Reset
REQ-028 SHALL, with rst_n low on a sys_clk edge, set: FSM IDLE; wr_pend, upd_pend, timer, hold, work, word index and round-robin pointer 0; cmd_data 0; cmd_vld 0; busy 0; upd_done 0.
REQ-029 SHALL abort any in-flight sequence on reset mid-operation with no further cmd_vld; the SPI master discards the partial transaction.

Structure
REQ-030 SHALL take from package dds_ftw_pkg: CH_SEL table {8'h41, 8'h82, 8'h14, 8'h28}; addresses 16'h0008, 16'h0113, 16'h0114; codes 8'h02 and 8'h03; FSM state encoding.
REQ-031 SHALL implement arbitration in one sub-module, rr_arb (NUM_CH requests, pointer in, one-hot grant out); all else is in dds_ftw_sched.

Verification
REQ-032 SHALL pass: ftw_vld[0] with ftw0=48'h0123456789AB, cmd_rdy=1 -> 000841, 011302, 0114AB, 011589, 011667, 011745, 011823, 011901; UPD_DLY cycles later 000841, 011303; upd_done=2'b01.
REQ-033 SHALL pass: ftw_vld[0] then ftw_vld[1] 100 cycles later -> both write sequences, then one coalesced update 0008C3, 011303; upd_done=2'b11.
REQ-034 SHALL pass: ftw_vld on both channels in the same cycle -> ch0 written first, ch1 next; a second simultaneous pair -> ch1 first (round-robin).
REQ-035 SHALL pass: cmd_rdy toggled randomly -> cmd_data unchanged while cmd_vld && !cmd_rdy, and no word lost or duplicated.
REQ-036 SHALL pass: ftw_vld[0] again during the ch0 WR sequence -> ch0 sequence repeats with the new value after DONE, and only one update is issued.
REQ-037 SHALL pass: rst_n low during word 4 of WR -> cmd_vld 0 next cycle, all outputs at reset values, and no update issued.
